// File: rtl/chess_move_pkg.sv
// Shared move-word layout, flag bit positions and gather state encoding.
// The end-of-list token is any move word whose INVALID flag bit is set.
package chess_move_pkg;

    localparam int MOVE_W = 19;
    localparam int FLAG_W = 7;
    localparam int SQ_W   = 6;

    localparam int FLAG_INVALID = 6;
    localparam int FLAG_PROMOTE = 5;
    localparam int FLAG_PAWN    = 4;
    localparam int FLAG_PAWN2   = 3;
    localparam int FLAG_EP      = 2;
    localparam int FLAG_CASTLE  = 1;
    localparam int FLAG_CAPTURE = 0;

    typedef enum logic [1:0] {
        ST_SELECT = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_DONE   = 2'd2
    } gather_state_t;

    function automatic logic is_end(input logic [FLAG_W-1:0] flags);
        return flags[FLAG_INVALID];
    endfunction

endpackage

// File: rtl/move_fifo.sv
// Synchronous show-ahead FIFO; full/empty come from registered occupancy,
// so a pop in the same cycle never frees room for a write.
module move_fifo #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full && !reset;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/move_gather_arbiter.sv
// Gathers per-square move lists into one ordered stream: one source at a time
// is drained up to its end token, then the next ready source is chosen.
module move_gather_arbiter
    import chess_move_pkg::*;
#(
    parameter int NUM_SRC    = 8,
    parameter int MOVE_W     = 19,
    parameter int FIFO_DEPTH = 16,
    parameter int RR_MODE    = 0,
    parameter int CNT_W      = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_SRC-1:0]        src_done,
    input  logic [NUM_SRC*MOVE_W-1:0] src_data,
    output logic [NUM_SRC-1:0]        src_rden,
    output logic [MOVE_W-1:0]         out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CNT_W-1:0]          move_count,
    output logic                      done
);

    localparam int IDX_W = $clog2(NUM_SRC);

    gather_state_t      state;
    gather_state_t      state_next;
    logic [NUM_SRC-1:0] drained;
    logic [NUM_SRC-1:0] cand;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   last;
    logic [IDX_W-1:0]   sel_idx;
    logic               sel_found;
    int                 rr_idx;
    logic [MOVE_W-1:0]  head;
    logic               head_end;
    logic               pop;
    logic               wr_en;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   count_r;
    logic               done_r;

    assign cand     = src_done & ~drained;
    assign head     = src_data[int'(ptr) * MOVE_W +: MOVE_W];
    assign head_end = is_end(head[MOVE_W-1 -: FLAG_W]);
    assign wr_en    = pop && !head_end;

    // Fixed priority lets the highest index overwrite; round-robin lets the
    // nearest index after the last served source overwrite.
    always_comb begin
        sel_idx   = '0;
        sel_found = 1'b0;
        rr_idx    = 0;
        if (RR_MODE == 0) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (cand[i]) begin
                    sel_idx   = IDX_W'(i);
                    sel_found = 1'b1;
                end
            end
        end else begin
            for (int k = NUM_SRC; k >= 1; k--) begin
                rr_idx = int'(last) + k;
                if (rr_idx >= NUM_SRC) rr_idx = rr_idx - NUM_SRC;
                if (cand[rr_idx]) begin
                    sel_idx   = IDX_W'(rr_idx);
                    sel_found = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= ST_SELECT;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        src_rden   = '0;
        case (state)
            ST_SELECT: begin
                if (&drained)       state_next = ST_DONE;
                else if (sel_found) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!fifo_full && src_done[ptr]) begin
                    pop = 1'b1;
                    if (head_end) state_next = ST_SELECT;
                end
            end
            ST_DONE:  state_next = ST_DONE;
            default:  state_next = ST_SELECT;
        endcase
        // A word shown during reset must stay at the source.
        if (reset) pop = 1'b0;
        src_rden[ptr] = pop;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drained <= '0;
            ptr     <= '0;
            last    <= IDX_W'(NUM_SRC - 1);
            count_r <= '0;
            done_r  <= 1'b0;
        end else begin
            if (state == ST_SELECT && sel_found) ptr <= sel_idx;
            if (pop && head_end) begin
                drained[ptr] <= 1'b1;
                last         <= ptr;
            end
            if (wr_en && count_r != '1) count_r <= count_r + 1'b1;
            done_r <= (state == ST_DONE) && fifo_empty;
        end
    end

    move_fifo #(
        .WIDTH (MOVE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_buf (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (head),
        .rd_en   (out_ready && !fifo_empty),
        .rd_data (out_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign out_valid  = !fifo_empty;
    assign move_count = count_r;
    assign done       = done_r;

endmodule

// File: tb/tb_move_gather_arbiter.sv
// Bench for move_gather_arbiter: a fixed-priority and a round-robin instance
// fed from per-source word queues, outputs scored against service-order lists.
module tb_move_gather_arbiter;

    localparam logic [18:0] END = 19'h40000;

    logic         clk;
    logic         reset;
    logic [7:0]   done_in [2];
    logic [151:0] data_in [2];
    logic [7:0]   rden [2];
    logic [18:0]  odata [2];
    logic         ovalid [2];
    logic         oready [2];
    logic         fin [2];
    logic [1:0]   mc_a;
    logic [7:0]   mc_b;

    logic [18:0]  srcq [16][$];
    logic [18:0]  expq [2][$];
    logic [7:0]   en [2];
    int           popcnt [16];
    int           exp_total [2];

    logic [7:0]   s_rden [2];
    logic         s_ovalid [2];
    logic         s_done [2];
    logic [7:0]   s_mc [2];

    int checks = 0;
    int failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    move_gather_arbiter #(
        .NUM_SRC(8), .MOVE_W(19), .FIFO_DEPTH(4), .RR_MODE(0), .CNT_W(2)
    ) dut_a (
        .clk(clk), .reset(reset), .src_done(done_in[0]), .src_data(data_in[0]),
        .src_rden(rden[0]), .out_data(odata[0]), .out_valid(ovalid[0]),
        .out_ready(oready[0]), .move_count(mc_a), .done(fin[0])
    );

    move_gather_arbiter #(
        .NUM_SRC(8), .MOVE_W(19), .FIFO_DEPTH(4), .RR_MODE(1), .CNT_W(8)
    ) dut_b (
        .clk(clk), .reset(reset), .src_done(done_in[1]), .src_data(data_in[1]),
        .src_rden(rden[1]), .out_data(odata[1]), .out_valid(ovalid[1]),
        .out_ready(oready[1]), .move_count(mc_b), .done(fin[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [18:0] rand_move();
        return {1'b0, 6'($urandom), 6'($urandom), 6'($urandom)};
    endfunction

    function automatic int sat(input int d, input int n);
        int lim;
        lim = (d == 0) ? 3 : 255;
        return (n > lim) ? lim : n;
    endfunction

    task automatic load_end_only(input int d);
        for (int i = 0; i < 8; i++) begin
            srcq[d*8+i].delete();
            srcq[d*8+i].push_back(END);
            popcnt[d*8+i] = 0;
        end
    endtask

    task automatic load_moves(input int k, input int n);
        srcq[k].delete();
        for (int w = 0; w < n; w++) srcq[k].push_back(rand_move());
        srcq[k].push_back(END);
        popcnt[k] = 0;
    endtask

    // All sources ready together: fixed priority serves 7..0, round-robin
    // after reset starts after source 7, i.e. serves 0..7.
    task automatic build_expected(input int d);
        expq[d].delete();
        for (int j = 0; j < 8; j++) begin
            int i;
            i = (d == 0) ? 7 - j : j;
            for (int w = 0; w < srcq[d*8+i].size(); w++) begin
                if (srcq[d*8+i][w][18]) break;
                expq[d].push_back(srcq[d*8+i][w]);
            end
        end
        exp_total[d] = expq[d].size();
    endtask

    task automatic drive_srcs();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 8; i++) begin
                done_in[d][i] = en[d][i];
                data_in[d][i*19 +: 19] = (srcq[d*8+i].size() > 0) ? srcq[d*8+i][0] : 19'($urandom);
            end
        end
    endtask

    task automatic cycle();
        logic [7:0]  pops [2];
        logic [18:0] exp_word;
        @(negedge clk);
        drive_srcs();
        #4;
        for (int d = 0; d < 2; d++) begin
            s_rden[d]   = rden[d];
            s_ovalid[d] = ovalid[d];
            s_done[d]   = fin[d];
            s_mc[d]     = (d == 0) ? {6'b0, mc_a} : mc_b;
            pops[d]     = rden[d];
            check("rden_onehot", 32'($onehot0(rden[d])), 32'd1);
            for (int i = 0; i < 8; i++) begin
                if (rden[d][i]) begin
                    check("pop_enabled", 32'(en[d][i]), 32'd1);
                    check("pop_nonempty", 32'(srcq[d*8+i].size() > 0), 32'd1);
                end
            end
            if (ovalid[d] && oready[d]) begin
                exp_word = (expq[d].size() > 0) ? expq[d].pop_front() : 19'h7FFFF;
                check("out_data", 32'(odata[d]), 32'(exp_word));
            end
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 8; i++) begin
                if (pops[d][i] && srcq[d*8+i].size() > 0) begin
                    void'(srcq[d*8+i].pop_front());
                    popcnt[d*8+i]++;
                end
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        oready[0] = 1'b0;
        oready[1] = 1'b0;
        cycle();
        check("rst_cycle_rden_a", 32'(s_rden[0]), 32'd0);
        check("rst_cycle_rden_b", 32'(s_rden[1]), 32'd0);
        reset = 1'b0;
        cycle();
        for (int d = 0; d < 2; d++) begin
            check("rst_valid", 32'(s_ovalid[d]), 32'd0);
            check("rst_count", 32'(s_mc[d]), 32'd0);
            check("rst_done", 32'(s_done[d]), 32'd0);
            check("rst_rden", 32'(s_rden[d]), 32'd0);
        end
    endtask

    task automatic run_until_done(input int d, input int maxc, input string tag);
        int n;
        n = 0;
        while (!s_done[d] && n < maxc) begin
            cycle();
            n++;
        end
        check(tag, 32'(s_done[d]), 32'd1);
    endtask

    task automatic check_final(input int d);
        check("all_moves_out", 32'(expq[d].size()), 32'd0);
        check("final_count", 32'(s_mc[d]), 32'(sat(d, exp_total[d])));
        check("final_valid", 32'(s_ovalid[d]), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        oready[0] = 1'b0;
        oready[1] = 1'b0;
        en[0] = '0;
        en[1] = '0;
        load_end_only(0);
        load_end_only(1);
        drive_srcs();

        // Fixed priority: source 7 holds two moves; words offered during reset.
        srcq[7].delete();
        srcq[7].push_back(19'h00ABC);
        srcq[7].push_back(19'h00DEF);
        srcq[7].push_back(END);
        en[0] = 8'hFF;
        do_reset();
        build_expected(0);
        oready[0] = 1'b1;
        run_until_done(0, 8*2+4+2, "fp_done");
        check_final(0);

        // Saturating counter: five moves on a 2-bit counter.
        load_end_only(0);
        load_moves(0, 5);
        en[0] = 8'hFF;
        do_reset();
        build_expected(0);
        oready[0] = 1'b1;
        run_until_done(0, 40, "sat_done");
        check_final(0);

        // Reset while draining with two moves buffered.
        load_end_only(0);
        load_moves(7, 5);
        en[0] = 8'hFF;
        do_reset();
        cycle();
        cycle();
        check("mid_valid_before", 32'(s_ovalid[0]), 32'd1);
        do_reset();
        check("mid_src_kept", 32'(srcq[7].size()), 32'd4);
        build_expected(0);
        oready[0] = 1'b1;
        run_until_done(0, 40, "mid_done");
        check_final(0);

        // Late source: source 3 withheld while the rest drain.
        load_end_only(0);
        load_moves(3, 2);
        en[0] = 8'hF7;
        do_reset();
        build_expected(0);
        oready[0] = 1'b1;
        repeat (20) cycle();
        check("late_done_low", 32'(s_done[0]), 32'd0);
        check("late_rden_low", 32'(s_rden[0]), 32'd0);
        check("late_valid_low", 32'(s_ovalid[0]), 32'd0);
        en[0] = 8'hFF;
        run_until_done(0, 30, "late_done");
        check_final(0);
        en[0] = '0;

        // Backpressure on the round-robin instance: source 0 holds six moves.
        load_end_only(1);
        load_moves(8, 6);
        en[1] = 8'hFF;
        do_reset();
        build_expected(1);
        repeat (9) cycle();
        check("bp_popped", 32'(popcnt[8]), 32'd4);
        check("bp_rden_low", 32'(s_rden[1]), 32'd0);
        check("bp_valid", 32'(s_ovalid[1]), 32'd1);
        oready[1] = 1'b1;
        run_until_done(1, 40, "bp_done");
        check_final(1);

        // Round-robin: source 5 ready first, source 2 three cycles later.
        load_end_only(1);
        load_moves(13, 1);
        load_moves(10, 1);
        en[1] = 8'h20;
        do_reset();
        expq[1].delete();
        expq[1].push_back(srcq[13][0]);
        expq[1].push_back(srcq[10][0]);
        exp_total[1] = 2;
        oready[1] = 1'b1;
        cycle();
        cycle();
        en[1] = 8'h24;
        repeat (6) cycle();
        check("rr_order_out", 32'(expq[1].size()), 32'd0);
        en[1] = 8'hFF;
        run_until_done(1, 30, "rr_done");
        check_final(1);

        // Randomised lists and consumer stalls on both instances.
        for (int r = 0; r < 3; r++) begin
            int n;
            for (int k = 0; k < 16; k++) load_moves(k, $urandom_range(0, 4));
            en[0] = 8'hFF;
            en[1] = 8'hFF;
            do_reset();
            build_expected(0);
            build_expected(1);
            n = 0;
            while (!(s_done[0] && s_done[1]) && n < 300) begin
                oready[0] = ($urandom_range(0, 3) != 0);
                oready[1] = ($urandom_range(0, 3) != 0);
                cycle();
                n++;
            end
            check("rand_done_a", 32'(s_done[0]), 32'd1);
            check("rand_done_b", 32'(s_done[1]), 32'd1);
            check_final(0);
            check_final(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
